// File: rtl/c2c_link_rx_master.sv
// rtl/c2c_link_rx_master.sv - far-side C2C link stage replaying request frames as AXI4 master transactions
//
// Purpose: consumes the 32-bit request frame stream (header, address-high,
// address-low, optional write data) and performs one AXI4 transaction at a
// time, returning read data and a single status word on the response stream.
//
// Ports:
//   clock, reset            sole clock, asynchronous active-high reset
//   io_in_*                 request frame stream (valid/ready/bits)
//   io_out_*                response frame stream (valid/ready/bits)
//   io_m_axi_aw_* / w_* / b_*   AXI4 write address, data, response channels
//   io_m_axi_ar_* / r_*         AXI4 read address, data channels
module c2c_link_rx_master #(
   parameter logic [3:0]  AXI_ID    = 4'd0,
   parameter int unsigned MAX_BEATS = 256
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        io_in_valid,
   output logic        io_in_ready,
   input  logic [31:0] io_in_bits,
   output logic        io_out_valid,
   input  logic        io_out_ready,
   output logic [31:0] io_out_bits,
   output logic        io_m_axi_aw_valid,
   input  logic        io_m_axi_aw_ready,
   output logic [3:0]  io_m_axi_aw_bits_id,
   output logic [31:0] io_m_axi_aw_bits_addr,
   output logic [7:0]  io_m_axi_aw_bits_len,
   output logic [2:0]  io_m_axi_aw_bits_size,
   output logic [1:0]  io_m_axi_aw_bits_burst,
   output logic        io_m_axi_w_valid,
   input  logic        io_m_axi_w_ready,
   output logic [31:0] io_m_axi_w_bits_data,
   output logic [3:0]  io_m_axi_w_bits_strb,
   output logic        io_m_axi_w_bits_last,
   input  logic        io_m_axi_b_valid,
   output logic        io_m_axi_b_ready,
   input  logic [3:0]  io_m_axi_b_bits_id,
   input  logic [1:0]  io_m_axi_b_bits_resp,
   output logic        io_m_axi_ar_valid,
   input  logic        io_m_axi_ar_ready,
   output logic [3:0]  io_m_axi_ar_bits_id,
   output logic [31:0] io_m_axi_ar_bits_addr,
   output logic [7:0]  io_m_axi_ar_bits_len,
   output logic [2:0]  io_m_axi_ar_bits_size,
   output logic [1:0]  io_m_axi_ar_bits_burst,
   input  logic        io_m_axi_r_valid,
   output logic        io_m_axi_r_ready,
   input  logic [3:0]  io_m_axi_r_bits_id,
   input  logic [31:0] io_m_axi_r_bits_data,
   input  logic [1:0]  io_m_axi_r_bits_resp,
   input  logic        io_m_axi_r_bits_last
);

   typedef enum logic [3:0] {
      S_HDR, S_AHI, S_ALO,
      S_WR_AW, S_WR_DATA, S_WR_B,
      S_RD_AR, S_RD_DATA,
      S_DRAIN, S_STS
   } state_t;

   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [16:0] MAX_BEATS_W = 17'(MAX_BEATS);

   state_t      state_q, state_d;
   logic        op_q, op_d;
   logic [15:0] beats_m1_q, beats_m1_d;
   logic [31:0] addr_q, addr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [1:0]  resp_q, resp_d;

   logic        in_ready_c, out_valid_c, aw_valid_c, w_valid_c, b_ready_c, ar_valid_c, r_ready_c;
   logic        cnt_last, oversize;
   logic [1:0]  resp_max;
   logic [31:0] status_word;

   // Response IDs are not checked: only one transaction is ever outstanding.
   logic unused_ids;
   assign unused_ids = ^{io_m_axi_b_bits_id, io_m_axi_r_bits_id};

   assign cnt_last    = (cnt_q == beats_m1_q);
   // beats > MAX_BEATS  <=>  beats-1 >= MAX_BEATS
   assign oversize    = ({1'b0, beats_m1_q} >= MAX_BEATS_W);
   assign resp_max    = (io_m_axi_r_bits_resp > resp_q) ? io_m_axi_r_bits_resp : resp_q;
   assign status_word = {1'b1, 12'd0, resp_q, op_q, beats_m1_q};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= S_HDR;
         op_q       <= 1'b0;
         beats_m1_q <= 16'd0;
         addr_q     <= 32'd0;
         cnt_q      <= 16'd0;
         resp_q     <= 2'b00;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         beats_m1_q <= beats_m1_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         resp_q     <= resp_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      beats_m1_d  = beats_m1_q;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      resp_d      = resp_q;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      aw_valid_c  = 1'b0;
      w_valid_c   = 1'b0;
      b_ready_c   = 1'b0;
      ar_valid_c  = 1'b0;
      r_ready_c   = 1'b0;

      unique case (state_q)
         S_HDR: begin
            in_ready_c = 1'b1;
            if (io_in_valid) begin
               op_d       = io_in_bits[16];
               beats_m1_d = io_in_bits[15:0];
               state_d    = S_AHI;
            end
         end
         S_AHI: begin
            in_ready_c = 1'b1;
            if (io_in_valid) state_d = S_ALO;
         end
         S_ALO: begin
            in_ready_c = 1'b1;
            if (io_in_valid) begin
               addr_d = io_in_bits;
               if (!oversize) begin
                  state_d = op_q ? S_WR_AW : S_RD_AR;
               end else if (op_q) begin
                  state_d = S_DRAIN;
               end else begin
                  // Oversize read is refused without touching AXI.
                  resp_d  = RESP_SLVERR;
                  state_d = S_STS;
               end
            end
         end
         S_WR_AW: begin
            aw_valid_c = 1'b1;
            if (io_m_axi_aw_ready) state_d = S_WR_DATA;
         end
         S_WR_DATA: begin
            w_valid_c  = io_in_valid;
            in_ready_c = io_m_axi_w_ready;
            if (io_in_valid && io_m_axi_w_ready) begin
               if (cnt_last) state_d = S_WR_B;
               else          cnt_d   = cnt_q + 16'd1;
            end
         end
         S_WR_B: begin
            b_ready_c = 1'b1;
            if (io_m_axi_b_valid) begin
               resp_d  = io_m_axi_b_bits_resp;
               state_d = S_STS;
            end
         end
         S_RD_AR: begin
            ar_valid_c = 1'b1;
            if (io_m_axi_ar_ready) state_d = S_RD_DATA;
         end
         S_RD_DATA: begin
            out_valid_c = io_m_axi_r_valid;
            r_ready_c   = io_out_ready;
            if (io_m_axi_r_valid && io_out_ready) begin
               // A misplaced r_last marks the burst as a slave error.
               resp_d = (io_m_axi_r_bits_last != cnt_last) ? RESP_SLVERR : resp_max;
               if (cnt_last) state_d = S_STS;
               else          cnt_d   = cnt_q + 16'd1;
            end
         end
         S_DRAIN: begin
            in_ready_c = 1'b1;
            if (io_in_valid) begin
               if (cnt_last) begin
                  resp_d  = RESP_SLVERR;
                  state_d = S_STS;
               end else begin
                  cnt_d = cnt_q + 16'd1;
               end
            end
         end
         S_STS: begin
            out_valid_c = 1'b1;
            if (io_out_ready) begin
               cnt_d   = 16'd0;
               resp_d  = 2'b00;
               state_d = S_HDR;
            end
         end
         default: state_d = S_HDR;
      endcase
   end

   // Handshake outputs are forced low for the whole reset pulse, not just
   // after the next edge, so a mid-transaction reset drops them immediately.
   assign io_in_ready       = in_ready_c  & ~reset;
   assign io_out_valid      = out_valid_c & ~reset;
   assign io_m_axi_aw_valid = aw_valid_c  & ~reset;
   assign io_m_axi_w_valid  = w_valid_c   & ~reset;
   assign io_m_axi_b_ready  = b_ready_c   & ~reset;
   assign io_m_axi_ar_valid = ar_valid_c  & ~reset;
   assign io_m_axi_r_ready  = r_ready_c   & ~reset;

   assign io_out_bits = (state_q == S_RD_DATA) ? io_m_axi_r_bits_data : status_word;

   assign io_m_axi_aw_bits_id    = AXI_ID;
   assign io_m_axi_aw_bits_addr  = addr_q;
   assign io_m_axi_aw_bits_len   = beats_m1_q[7:0];
   assign io_m_axi_aw_bits_size  = 3'b010;
   assign io_m_axi_aw_bits_burst = 2'b01;

   assign io_m_axi_w_bits_data = io_in_bits;
   assign io_m_axi_w_bits_strb = 4'hF;
   assign io_m_axi_w_bits_last = (state_q == S_WR_DATA) && cnt_last;

   assign io_m_axi_ar_bits_id    = AXI_ID;
   assign io_m_axi_ar_bits_addr  = addr_q;
   assign io_m_axi_ar_bits_len   = beats_m1_q[7:0];
   assign io_m_axi_ar_bits_size  = 3'b010;
   assign io_m_axi_ar_bits_burst = 2'b01;

endmodule

// File: tb/tb_c2c_link_rx_master.sv
// tb/tb_c2c_link_rx_master.sv - directed self-checking bench for c2c_link_rx_master
module tb_c2c_link_rx_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        io_in_valid, io_in_ready;
   logic [31:0] io_in_bits;
   logic        io_out_valid, io_out_ready;
   logic [31:0] io_out_bits;
   logic        aw_valid, aw_ready;
   logic [3:0]  aw_id;
   logic [31:0] aw_addr;
   logic [7:0]  aw_len;
   logic [2:0]  aw_size;
   logic [1:0]  aw_burst;
   logic        w_valid, w_ready;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        w_last;
   logic        b_valid, b_ready;
   logic [3:0]  b_id;
   logic [1:0]  b_resp;
   logic        ar_valid, ar_ready;
   logic [3:0]  ar_id;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic [2:0]  ar_size;
   logic [1:0]  ar_burst;
   logic        r_valid, r_ready;
   logic [3:0]  r_id;
   logic [31:0] r_data;
   logic [1:0]  r_resp;
   logic        r_last;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] wd [4];
   logic [31:0] rd [4];
   logic [1:0]  rr [4];

   c2c_link_rx_master #(.AXI_ID(4'd0), .MAX_BEATS(256)) dut (
      .clock(clock), .reset(reset),
      .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
      .io_out_valid(io_out_valid), .io_out_ready(io_out_ready), .io_out_bits(io_out_bits),
      .io_m_axi_aw_valid(aw_valid), .io_m_axi_aw_ready(aw_ready), .io_m_axi_aw_bits_id(aw_id),
      .io_m_axi_aw_bits_addr(aw_addr), .io_m_axi_aw_bits_len(aw_len),
      .io_m_axi_aw_bits_size(aw_size), .io_m_axi_aw_bits_burst(aw_burst),
      .io_m_axi_w_valid(w_valid), .io_m_axi_w_ready(w_ready), .io_m_axi_w_bits_data(w_data),
      .io_m_axi_w_bits_strb(w_strb), .io_m_axi_w_bits_last(w_last),
      .io_m_axi_b_valid(b_valid), .io_m_axi_b_ready(b_ready), .io_m_axi_b_bits_id(b_id),
      .io_m_axi_b_bits_resp(b_resp),
      .io_m_axi_ar_valid(ar_valid), .io_m_axi_ar_ready(ar_ready), .io_m_axi_ar_bits_id(ar_id),
      .io_m_axi_ar_bits_addr(ar_addr), .io_m_axi_ar_bits_len(ar_len),
      .io_m_axi_ar_bits_size(ar_size), .io_m_axi_ar_bits_burst(ar_burst),
      .io_m_axi_r_valid(r_valid), .io_m_axi_r_ready(r_ready), .io_m_axi_r_bits_id(r_id),
      .io_m_axi_r_bits_data(r_data), .io_m_axi_r_bits_resp(r_resp), .io_m_axi_r_bits_last(r_last)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [6:0] hs_outs();
      return {io_in_ready, io_out_valid, aw_valid, w_valid, ar_valid, b_ready, r_ready};
   endfunction

   task automatic send_word(input string tag, input logic [31:0] w);
      logic ok;
      ok = 1'b0;
      io_in_valid = 1'b1;
      io_in_bits  = w;
      for (int n = 0; n < 20; n++) begin
         #1;
         if (io_in_ready) begin
            tick();
            ok = 1'b1;
            break;
         end
         tick();
      end
      io_in_valid = 1'b0;
      chk(tag, ok, 1'b1);
   endtask

   task automatic check_status(input string tag, input logic [31:0] exp_sts);
      #1;
      chk({tag, "_sts_valid"}, io_out_valid, 1'b1);
      chk({tag, "_sts_word"}, io_out_bits, exp_sts);
      io_out_ready = 1'b1;
      tick();
      io_out_ready = 1'b0;
   endtask

   // rst_after < beats: reset is asserted after that many W handshakes.
   task automatic do_write(input string tag, input logic [31:0] addr, input int beats,
                           input bit toggle, input logic [1:0] bresp,
                           input logic [31:0] exp_sts, input int rst_after);
      int idx, cyc;
      send_word({tag, "_hdr"}, 32'h0001_0000 | 32'(beats - 1));
      send_word({tag, "_ahi"}, 32'h0);
      send_word({tag, "_alo"}, addr);
      chk({tag, "_aw_valid"}, aw_valid, 1'b1);
      chk({tag, "_aw_addr"}, aw_addr, addr);
      chk({tag, "_aw_len"}, aw_len, 32'(beats - 1));
      chk({tag, "_aw_fixed"}, {aw_id, aw_size, aw_burst}, {4'd0, 3'b010, 2'b01});
      chk({tag, "_aw_in_rdy"}, io_in_ready, 1'b0);
      aw_ready = 1'b1;
      tick();
      aw_ready = 1'b0;
      idx = 0;
      cyc = 0;
      while (idx < beats && cyc < 40) begin
         if (idx == rst_after) break;
         io_in_valid = 1'b1;
         io_in_bits  = wd[idx];
         w_ready     = toggle ? (cyc % 2 == 1) : 1'b1;
         #1;
         chk({tag, "_w_valid"}, w_valid, 1'b1);
         chk({tag, "_w_data"}, w_data, wd[idx]);
         chk({tag, "_w_strb"}, w_strb, 4'hF);
         chk({tag, "_in_rdy_w"}, io_in_ready, w_ready);
         if (w_ready) begin
            chk({tag, "_w_last"}, w_last, (idx == beats - 1));
            idx++;
         end
         tick();
         cyc++;
      end
      if (idx == rst_after) begin
         io_in_valid = 1'b1;
         w_ready     = 1'b1;
         #2;
         reset = 1'b1;
         #1;
         chk({tag, "_rst_outs"}, hs_outs(), 7'd0);
         tick();
         chk({tag, "_rst_outs_hold"}, hs_outs(), 7'd0);
         io_in_valid = 1'b0;
         w_ready     = 1'b0;
         reset       = 1'b0;
         tick();
         chk({tag, "_post_rst_in_rdy"}, io_in_ready, 1'b1);
      end else begin
         io_in_valid = 1'b0;
         w_ready     = 1'b0;
         chk({tag, "_w_count"}, idx, beats);
         chk({tag, "_b_ready"}, b_ready, 1'b1);
         chk({tag, "_out_idle"}, io_out_valid, 1'b0);
         b_valid = 1'b1;
         b_resp  = bresp;
         tick();
         b_valid = 1'b0;
         b_resp  = 2'b00;
         check_status(tag, exp_sts);
      end
   endtask

   task automatic do_read(input string tag, input logic [31:0] addr, input int beats,
                          input int stall_beat, input int stall_cycles,
                          input logic [31:0] exp_sts);
      send_word({tag, "_hdr"}, 32'(beats - 1));
      send_word({tag, "_ahi"}, 32'h0);
      send_word({tag, "_alo"}, addr);
      chk({tag, "_ar_valid"}, ar_valid, 1'b1);
      chk({tag, "_ar_addr"}, ar_addr, addr);
      chk({tag, "_ar_len"}, ar_len, 32'(beats - 1));
      chk({tag, "_ar_fixed"}, {ar_id, ar_size, ar_burst}, {4'd0, 3'b010, 2'b01});
      chk({tag, "_aw_quiet"}, aw_valid, 1'b0);
      ar_ready = 1'b1;
      tick();
      ar_ready = 1'b0;
      for (int i = 0; i < beats; i++) begin
         r_valid = 1'b1;
         r_data  = rd[i];
         r_resp  = rr[i];
         r_last  = (i == beats - 1);
         if (i == stall_beat) begin
            for (int s = 0; s < stall_cycles; s++) begin
               io_out_ready = 1'b0;
               #1;
               chk({tag, "_stall_r_rdy"}, r_ready, 1'b0);
               chk({tag, "_stall_data"}, io_out_bits, rd[i]);
               tick();
            end
         end
         io_out_ready = 1'b1;
         #1;
         chk({tag, "_out_valid"}, io_out_valid, 1'b1);
         chk({tag, "_r_ready"}, r_ready, 1'b1);
         chk({tag, "_out_data"}, io_out_bits, rd[i]);
         tick();
      end
      io_out_ready = 1'b0;
      // A stray beat during the status phase must not be accepted.
      r_valid = 1'b1;
      r_last  = 1'b0;
      r_data  = 32'hBAD0_BAD0;
      #1;
      chk({tag, "_stray_r_rdy"}, r_ready, 1'b0);
      check_status(tag, exp_sts);
      r_valid = 1'b0;
      r_resp  = 2'b00;
   endtask

   initial begin
      reset = 1'b1;
      io_in_valid = 1'b0; io_in_bits = 32'h0; io_out_ready = 1'b0;
      aw_ready = 1'b0; w_ready = 1'b0; b_valid = 1'b0; b_id = 4'd0; b_resp = 2'b00;
      ar_ready = 1'b0; r_valid = 1'b0; r_id = 4'd0; r_data = 32'h0; r_resp = 2'b00; r_last = 1'b0;

      repeat (2) @(posedge clock);
      #1;
      chk("reset_outs", hs_outs(), 7'd0);
      reset = 1'b0;
      tick();
      chk("idle_in_ready", io_in_ready, 1'b1);
      chk("idle_out_valid", io_out_valid, 1'b0);

      wd[0] = 32'h1111_1111;
      do_write("wr1", 32'h0, 1, 1'b0, 2'b00, 32'h8001_0000, -1);

      rd[0] = 32'hDEAD_BEEF; rr[0] = 2'b00;
      do_read("rd1", 32'h24, 1, -1, 0, 32'h8000_0000);

      wd[0] = 32'hAABB_CCDD; wd[1] = 32'h2222_2222; wd[2] = 32'h3333_3333; wd[3] = 32'h4444_4444;
      do_write("wr4", 32'h3000, 4, 1'b1, 2'b00, 32'h8001_0003, -1);

      rd[0] = 32'h0101_0101; rd[1] = 32'h0202_0202; rd[2] = 32'h0303_0303; rd[3] = 32'h0404_0404;
      rr[0] = 2'b00; rr[1] = 2'b00; rr[2] = 2'b10; rr[3] = 2'b00;
      do_read("rd4", 32'h4000, 4, 2, 3, 32'h8004_0003);

      send_word("ovw_hdr", 32'h0001_012B);
      send_word("ovw_ahi", 32'h0);
      send_word("ovw_alo", 32'h5000);
      for (int i = 0; i < 300; i++) begin
         io_in_valid = 1'b1;
         io_in_bits  = 32'(i);
         #1;
         chk("ovw_drain", {io_in_ready, io_out_valid, aw_valid, w_valid}, 4'b1000);
         tick();
      end
      io_in_valid = 1'b0;
      check_status("ovw", 32'h8005_012B);

      send_word("ovr_hdr", 32'h0000_012B);
      send_word("ovr_ahi", 32'h0);
      send_word("ovr_alo", 32'h6000);
      chk("ovr_no_ar", ar_valid, 1'b0);
      check_status("ovr", 32'h8004_012B);

      wd[0] = 32'h5555_5555;
      do_write("wrerr", 32'h10, 1, 1'b0, 2'b10, 32'h8005_0000, -1);

      wd[0] = 32'hA0A0_A0A0; wd[1] = 32'hB1B1_B1B1; wd[2] = 32'hC2C2_C2C2; wd[3] = 32'hD3D3_D3D3;
      do_write("wrrst", 32'h7000, 4, 1'b0, 2'b00, 32'h0, 2);

      wd[0] = 32'h1234_5678;
      do_write("wrpost", 32'h8, 1, 1'b0, 2'b00, 32'h8001_0000, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/c2c_link_rx_master.md
Name: c2c_link_rx_master

Overview:
- Far-side terminating stage of the chip-to-chip link. It consumes the 32-bit request frame stream produced by the C2CLink AXI4 slave bridge and replays each request as an AXI4 master transaction.
- It returns a response frame stream toward the requester.
- Single outstanding transaction, 32-bit data, 32-bit address.

Parameters:
- AXI_ID, 0, constant ID driven on AW/AR; B/R IDs are ignored.
- MAX_BEATS, 256, maximum burst beats replayed on AXI. Fixed by the 8-bit AXI len field; must be ≤256.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high.
- io_in_valid / io_in_ready / io_in_bits  in/out/in  1/1/32  request frame stream.
- io_out_valid / io_out_ready / io_out_bits  out/in/out  1/1/32  response frame stream.
- io_m_axi_aw_valid / _ready / _bits_id / _bits_addr / _bits_len / _bits_size / _bits_burst  out/in/out/out/out/out/out  1/1/4/32/8/3/2  AW channel.
- io_m_axi_w_valid / _ready / _bits_data / _bits_strb / _bits_last  out/in/out/out/out  1/1/32/4/1  W channel.
- io_m_axi_b_valid / _ready / _bits_id / _bits_resp  in/out/in/in  1/1/4/2  B channel.
- io_m_axi_ar_valid / _ready / _bits_id / _bits_addr / _bits_len / _bits_size / _bits_burst  out/in/out/out/out/out/out  1/1/4/32/8/3/2  AR channel.
- io_m_axi_r_valid / _ready / _bits_id / _bits_data / _bits_resp / _bits_last  in/out/in/in/in/in  1/1/4/32/2/1  R channel.

Behaviour:
- Request frame format:
  - Word 0 is the header: [16]=op (1 = write), [15:0]=beats-1. Bits [31:17] are ignored.
  - Word 1 is address-high: captured, not used.
  - Word 2 is address-low.
  - Writes then carry beats data words. Reads carry none.
- Response frame format, one status word: [31]=1, [30:19]=0, [18:17]=resp, [16]=op echo, [15:0]=beats-1 echo.
  - Writes: status word only.
  - Reads: beats data words, then the status word.
- AXI constants: size=3'b010, burst=2'b01 (INCR), strb=4'hF, id=AXI_ID. 4KB-boundary crossing is not checked.
- FSM states: HDR, AHI, ALO, then one of two paths.
  - Write: WR_AW, WR_DATA, WR_B, STS.
  - Read: RD_AR, RD_DATA, STS.
  - Oversize: DRAIN, STS.
- io_in_ready=1 in HDR, AHI and ALO. Each accepted word advances one state.
- Leaving ALO:
  - Legal write goes to WR_AW.
  - Legal read goes to RD_AR.
  - Write with beats>MAX_BEATS goes to DRAIN.
  - Read with beats>MAX_BEATS goes to STS with resp=2'b10 (SLVERR); no AXI traffic.
- Address phase: aw_valid/ar_valid rise the cycle after the ALO handshake and hold until ready. addr=address-low, len=(beats-1)[7:0].
- WR_DATA is a combinational pass-through:
  - w_valid=io_in_valid, io_in_ready=w_ready, w_data=io_in_bits.
  - w_last=1 when the 16-bit beat counter equals beats-1.
  - After the last handshake go to WR_B.
- WR_B: b_ready=1. Capture b_resp and go to STS.
- DRAIN: io_in_ready=1. Discard beats words, then go to STS with resp=2'b10.
- RD_DATA is a combinational pass-through:
  - io_out_valid=r_valid, r_ready=io_out_ready, io_out_bits=r_data.
  - Status resp accumulates as the maximum r_resp seen across beats.
  - If r_last does not coincide with counter==beats-1, resp is forced to 2'b10.
  - Exit to STS after beats handshakes. Any stray R beats after that point are not accepted.
- STS: io_out_valid=1 holding the status word until io_out_ready, then return to HDR. Reset resp/counter on entry to HDR.
- io_out_valid=0 in every state other than RD_DATA and STS. io_in_ready=0 in RD_AR, RD_DATA, WR_AW, WR_B and STS (no pipelining of the next request).
- Reset, asynchronous, effective at any time including mid-transaction:
  - State returns to HDR; counter and resp are cleared.
  - All valid/ready outputs go to 0: io_in_ready, io_out_valid, aw/w/ar_valid, b/r_ready.
  - An in-flight AXI transaction is abandoned; clean recovery is the system's responsibility.
- Minimum latency: AW valid 1 cycle after the ALO handshake. Status word 1 cycle after the B handshake.

Test Plan:
- Write, 1 beat: in 0x00010000, 0, 0x0, 0x11111111; slave returns B OKAY.
  -> AW addr=0x0, len=0, id=AXI_ID. One W 0x11111111 with last=1. io_out 0x80010000.
- Read, 1 beat: in 0x00000000, 0, 0x24; slave returns R 0xDEADBEEF, last, OKAY.
  -> AR addr=0x24, len=0. io_out 0xDEADBEEF then 0x80000000.
- Write, 4 beats at 0x3000: data 0xAABBCCDD, 0x22222222, 0x33333333, 0x44444444; w_ready toggles every other cycle.
  -> AW len=3. W beats in order with last only on the 4th. Status 0x80010003.
- Read, 4 beats with io_out_ready low for 3 cycles mid-burst.
  -> r_ready tracks io_out_ready, no beat lost or duplicated. Slave returns r_resp=2'b10 on beat 2 -> status 0x80040003.
- Oversize write, header 0x0001012B (300 beats).
  -> No AW/W. 300 words drained. io_out 0x8005012B.
  -> Also: a B SLVERR on a 1-beat write yields 0x80050000.
- Reset asserted during WR_DATA after beat 2 of 4.
  -> All outputs 0 immediately. A subsequent 1-beat write completes normally with status 0x80010000.
